multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu
//
// Multi-cycle ALU with a start/busy/done handshake. When a start is accepted,
// the operands and the operation code are captured. The result is computed in
// EXEC, and done_o pulses for one cycle in DONE. The registered result and
// flags hold their values until the next completion or reset.
//
// Operation codes:
//   1 A-B, 2 A|B, 3 A+B, 4 LUI (B<<16), 5 SLL B<<shamt, 6 SRL B>>shamt,
//   7 A&B, 8 ~(A|B).
//   Any other code completes with result 0, zero_o 1 and invalid_op_o 1.
//
// Build option:
//   ALU_SERIAL_SHIFT_EN
//     Defined: codes 5/6 go through a SHIFT state that moves one bit per
//     cycle, so done_o arrives shamt+2 cycles after start.
//     Undefined (default): shifts use a barrel shifter in EXEC, so done_o
//     arrives 2 cycles after start.
//
// Ports:
//   clk              clock; all state changes on the rising edge
//   reset            synchronous active-high reset
//   start_i          start request, accepted in IDLE or DONE
//   alu_operation_i  4-bit operation code
//   a_data_i         operand A
//   b_data_i         operand B
//   shamt_i          5-bit shift amount
//   result_o         registered result
//   zero_o           high when result_o == 0
//   busy_o           high while in EXEC or SHIFT
//   done_o           one-cycle pulse; result_o is valid in that cycle
//   invalid_op_o     the last completed code was unsupported
// ---------------------------------------------------------------------------
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic [4:0]            shamt_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  invalid_op_o
);

  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_LUI = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd8;

`ifdef ALU_SERIAL_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t                state_reg, state_next;
  logic [3:0]            op_reg, op_next;
  logic [DATA_WIDTH-1:0] a_reg, a_next;
  // In the serial build, b_reg is also the working shift register and
  // shamt_reg counts the remaining shift steps.
  logic [DATA_WIDTH-1:0] b_reg, b_next;
  logic [4:0]            shamt_reg, shamt_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;
  logic                  zero_reg, zero_next;
  logic                  invalid_reg, invalid_next;

  logic                  accept;
  logic [DATA_WIDTH-1:0] exec_result;
  logic                  exec_invalid;

`ifndef ALU_SERIAL_SHIFT_EN
  // Log-depth barrel shifter: stage i shifts by 2**i when shamt bit i is set.
  logic [DATA_WIDTH-1:0] shl_val;
  logic [DATA_WIDTH-1:0] shr_val;

  always_comb begin
    shl_val = b_reg;
    shr_val = b_reg;
    for (int i = 0; i < 5; i++) begin
      if (shamt_reg[i]) begin
        shl_val = shl_val << (1 << i);
        shr_val = shr_val >> (1 << i);
      end
    end
  end
`endif

  // Result of the single-cycle operations, computed from the captured inputs.
  always_comb begin
    exec_result  = '0;
    exec_invalid = 1'b0;
    case (op_reg)
      OP_SUB: exec_result = a_reg - b_reg;
      OP_OR:  exec_result = a_reg | b_reg;
      OP_ADD: exec_result = a_reg + b_reg;
      OP_LUI: exec_result = b_reg << 16;
`ifdef ALU_SERIAL_SHIFT_EN
      // Shift codes never enter EXEC in this build.
      OP_SLL, OP_SRL: exec_result = '0;
`else
      OP_SLL: exec_result = shl_val;
      OP_SRL: exec_result = shr_val;
`endif
      OP_AND: exec_result = a_reg & b_reg;
      OP_NOR: exec_result = ~(a_reg | b_reg);
      default: begin
        exec_result  = '0;
        exec_invalid = 1'b1;
      end
    endcase
  end

  assign accept = start_i && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    shamt_next   = shamt_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    invalid_next = invalid_reg;

    case (state_reg)
      IDLE: state_next = IDLE;
      EXEC: begin
        result_next  = exec_result;
        zero_next    = (exec_result == '0);
        invalid_next = exec_invalid;
        state_next   = DONE;
      end
`ifdef ALU_SERIAL_SHIFT_EN
      SHIFT: begin
        if (shamt_reg != 5'd0) begin
          b_next     = (op_reg == OP_SLL) ? (b_reg << 1) : (b_reg >> 1);
          shamt_next = shamt_reg - 5'd1;
        end else begin
          result_next  = b_reg;
          zero_next    = (b_reg == '0);
          invalid_next = 1'b0;
          state_next   = DONE;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A start can only be accepted in IDLE or DONE, so this overrides
    // nothing but the idle/return transition chosen above.
    if (accept) begin
      op_next    = alu_operation_i;
      a_next     = a_data_i;
      b_next     = b_data_i;
      shamt_next = shamt_i;
`ifdef ALU_SERIAL_SHIFT_EN
      if ((alu_operation_i == OP_SLL) || (alu_operation_i == OP_SRL)) begin
        state_next = SHIFT;
      end else begin
        state_next = EXEC;
      end
`else
      state_next = EXEC;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      shamt_reg   <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      invalid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      shamt_reg   <= shamt_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      invalid_reg <= invalid_next;
    end
  end

  assign result_o     = result_reg;
  assign zero_o       = zero_reg;
  assign invalid_op_o = invalid_reg;
  assign done_o       = (state_reg == DONE);
`ifdef ALU_SERIAL_SHIFT_EN
  assign busy_o       = (state_reg == EXEC) || (state_reg == SHIFT);
`else
  assign busy_o       = (state_reg == EXEC);
`endif

endmodule
